// File: rtl/vga_sync_generator.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_generator
// Description : Pixel-clock timing master for the VGA output path.
//               Produces the X/Y raster position, sync pulses, active-video
//               enable, vertical blank and frame-start flags. It also owns
//               front/back buffer selection, swapping only on the frame-wrap
//               edge in response to a level request from the pixel producer.
// Ports       : SYNC_CLK         pixel clock (single domain)
//               SYNC_RST_N       synchronous active-low reset
//               SYNC_SWAP_REQ    producer request to swap at next frame wrap
//               SYNC_POS_X/Y     current column / line
//               SYNC_ENABLE      active-video region
//               SYNC_HSYNC/VSYNC sync pulses, polarity per *_POL
//               SYNC_VBLANK      line is in vertical blanking
//               SYNC_FRAME_START high while POS = (0,0)
//               SYNC_SEL_BUFF    displayed buffer index
//               SYNC_DRAW_BUFF   buffer index the producer may write
//               SYNC_SWAP_ACK    one-cycle pulse in the (0,0) cycle of a swap
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_generator #(
    parameter int H_VISIBLE = 800,
    parameter int H_FRONT   = 56,
    parameter int H_SYNC    = 120,
    parameter int H_BACK    = 64,
    parameter int V_VISIBLE = 600,
    parameter int V_FRONT   = 37,
    parameter int V_SYNC    = 6,
    parameter int V_BACK    = 23,
    parameter bit HSYNC_POL = 1'b1,
    parameter bit VSYNC_POL = 1'b1
) (
    input  logic        SYNC_CLK,
    input  logic        SYNC_RST_N,
    input  logic        SYNC_SWAP_REQ,
    output logic [10:0] SYNC_POS_X,
    output logic [9:0]  SYNC_POS_Y,
    output logic        SYNC_ENABLE,
    output logic        SYNC_HSYNC,
    output logic        SYNC_VSYNC,
    output logic        SYNC_VBLANK,
    output logic        SYNC_FRAME_START,
    output logic        SYNC_SEL_BUFF,
    output logic        SYNC_DRAW_BUFF,
    output logic        SYNC_SWAP_ACK
);

    localparam logic [10:0] c_x_last     = 11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [10:0] c_x_visible  = 11'(H_VISIBLE);
    localparam logic [10:0] c_hs_first   = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] c_hs_last    = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0]  c_y_last     = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0]  c_y_visible  = 10'(V_VISIBLE);
    localparam logic [9:0]  c_vs_first   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0]  c_vs_last    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_PENDING = 1'b1
    } swap_state_t;

    swap_state_t r_state;

    logic [10:0] r_x;
    logic [9:0]  r_y;
    logic        r_enable;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_vblank;
    logic        r_frame_start;
    logic        r_sel;
    logic        r_draw;
    logic        r_ack;

    logic        w_x_wrap;
    logic        w_frame_wrap;
    logic [10:0] w_next_x;
    logic [9:0]  w_next_y;

    // Next position; all flags are decoded from it so they line up with the
    // registered position they describe.
    always_comb begin
        w_x_wrap     = (r_x == c_x_last);
        w_frame_wrap = w_x_wrap && (r_y == c_y_last);
        w_next_x     = w_x_wrap ? 11'd0 : r_x + 11'd1;
        w_next_y     = r_y;
        if (w_x_wrap) begin
            w_next_y = (r_y == c_y_last) ? 10'd0 : r_y + 10'd1;
        end
    end

    always_ff @(posedge SYNC_CLK) begin
        if (!SYNC_RST_N) begin
            r_x           <= 11'd0;
            r_y           <= 10'd0;
            r_enable      <= 1'b0;
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_vblank      <= 1'b0;
            r_frame_start <= 1'b0;
            r_sel         <= 1'b0;
            r_draw        <= 1'b1;
            r_ack         <= 1'b0;
            r_state       <= S_IDLE;
        end else begin
            r_x           <= w_next_x;
            r_y           <= w_next_y;
            r_enable      <= (w_next_x < c_x_visible) && (w_next_y < c_y_visible);
            r_hsync       <= ((w_next_x >= c_hs_first) && (w_next_x <= c_hs_last))
                             ? HSYNC_POL : ~HSYNC_POL;
            r_vsync       <= ((w_next_y >= c_vs_first) && (w_next_y <= c_vs_last))
                             ? VSYNC_POL : ~VSYNC_POL;
            r_vblank      <= (w_next_y >= c_y_visible);
            r_frame_start <= (w_next_x == 11'd0) && (w_next_y == 10'd0);
            r_ack         <= 1'b0;

            // A request seen on the last-pixel cycle itself swaps on that
            // same edge; otherwise it waits in PENDING, which a later drop
            // of the request cannot cancel.
            case (r_state)
                S_IDLE: begin
                    if (SYNC_SWAP_REQ) begin
                        if (w_frame_wrap) begin
                            r_sel  <= ~r_sel;
                            r_draw <= r_sel;
                            r_ack  <= 1'b1;
                        end else begin
                            r_state <= S_PENDING;
                        end
                    end
                end
                S_PENDING: begin
                    if (w_frame_wrap) begin
                        r_sel   <= ~r_sel;
                        r_draw  <= r_sel;
                        r_ack   <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign SYNC_POS_X       = r_x;
    assign SYNC_POS_Y       = r_y;
    assign SYNC_ENABLE      = r_enable;
    assign SYNC_HSYNC       = r_hsync;
    assign SYNC_VSYNC       = r_vsync;
    assign SYNC_VBLANK      = r_vblank;
    assign SYNC_FRAME_START = r_frame_start;
    assign SYNC_SEL_BUFF    = r_sel;
    assign SYNC_DRAW_BUFF   = r_draw;
    assign SYNC_SWAP_ACK    = r_ack;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_sync_generator
// Description : Self-checking bench for vga_sync_generator using a reduced
//               raster (23 x 18 total, 16 x 12 visible) so whole frames run
//               quickly. Stimulus pushes the expected outputs for every edge
//               into a queue; an independent monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_generator;

    // Reduced timing: H 16+2+3+2 = 23, V 12+2+2+2 = 18, frame = 414 clocks.
    // Hand-derived windows: HSYNC X 18..20, VSYNC Y 14..15, VBLANK Y >= 12.
    localparam int c_x_last   = 22;
    localparam int c_y_last   = 17;
    localparam int c_frame    = 414;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
        logic        en;
        logic        hs;
        logic        vs;
        logic        vb;
        logic        fs;
        logic        sel;
        logic        draw;
        logic        ack;
    } obs_t;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [10:0] pos_x;
    logic [9:0]  pos_y;
    logic        enable, hsync, vsync, vblank, frame_start, sel_buff, draw_buff, swap_ack;

    vga_sync_generator #(
        .H_VISIBLE (16), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
        .V_VISIBLE (12), .V_FRONT (2), .V_SYNC (2), .V_BACK (2),
        .HSYNC_POL (1'b1), .VSYNC_POL (1'b1)
    ) dut (
        .SYNC_CLK         (clk),
        .SYNC_RST_N       (rst_n),
        .SYNC_SWAP_REQ    (req),
        .SYNC_POS_X       (pos_x),
        .SYNC_POS_Y       (pos_y),
        .SYNC_ENABLE      (enable),
        .SYNC_HSYNC       (hsync),
        .SYNC_VSYNC       (vsync),
        .SYNC_VBLANK      (vblank),
        .SYNC_FRAME_START (frame_start),
        .SYNC_SEL_BUFF    (sel_buff),
        .SYNC_DRAW_BUFF   (draw_buff),
        .SYNC_SWAP_ACK    (swap_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    obs_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   ack_seen = 0;
    int   fs_seen  = 0;

    // Bench-side expectation state: position after the last edge.
    int   ex = 0;
    int   ey = 0;
    bit   esel = 1'b0;
    bit   epend = 1'b0;

    // Monitor: every edge presents one output set; compare it to the queue.
    obs_t m_exp;
    obs_t m_act;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            m_exp = exp_q.pop_front();
            m_act = {pos_x, pos_y, enable, hsync, vsync, vblank, frame_start,
                     sel_buff, draw_buff, swap_ack};
            n_tests++;
            if (m_act !== m_exp) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t: got pos=(%0d,%0d) en,hs,vs,vb,fs,sel,draw,ack=%b, expected pos=(%0d,%0d) flags=%b",
                         $time, m_act.x, m_act.y, m_act[7:0], m_exp.x, m_exp.y, m_exp[7:0]);
            end
            if (m_act.ack === 1'b1) ack_seen++;
            if (m_act.fs === 1'b1) fs_seen++;
        end
    end

    task automatic chk(input string name, input int got, input int expv);
        n_tests++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    // One clock edge with the inputs currently driven; push the expected
    // outputs for that edge, then return at the falling edge.
    task automatic tick();
        obs_t e;
        bit   wrap;
        @(posedge clk);
        e = '0;
        if (!rst_n) begin
            ex = 0; ey = 0; esel = 1'b0; epend = 1'b0;
            e.draw = 1'b1;
        end else begin
            wrap = (ex == c_x_last) && (ey == c_y_last);
            if ((epend || req) && wrap) begin
                esel  = ~esel;
                epend = 1'b0;
                e.ack = 1'b1;
            end else if (req) begin
                epend = 1'b1;
            end
            if (ex == c_x_last) begin
                ex = 0;
                ey = (ey == c_y_last) ? 0 : ey + 1;
            end else begin
                ex = ex + 1;
            end
            e.en = (ex < 16) && (ey < 12);
            e.hs = (ex >= 18) && (ex <= 20);
            e.vs = (ey >= 14) && (ey <= 15);
            e.vb = (ey >= 12);
            e.fs = (ex == 0) && (ey == 0);
        end
        e.x    = 11'(ex);
        e.y    = 10'(ey);
        e.sel  = esel;
        e.draw = ~esel;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run_until(input int tx, input int ty);
        int n;
        n = 0;
        while (!(ex == tx && ey == ty) && n < 2 * c_frame) begin
            tick();
            n++;
        end
        if (!(ex == tx && ey == ty)) begin
            n_tests++;
            n_fail++;
            $display("FAIL run_until: position (%0d,%0d) not reached, at (%0d,%0d)", tx, ty, ex, ey);
        end
    endtask

    int a0;
    int f0;

    initial begin
        rst_n = 1'b0;
        req   = 1'b0;

        // Reset held for five edges, then release.
        repeat (5) tick();
        chk("reset_pos_x", int'(pos_x), 0);
        chk("reset_draw", int'(draw_buff), 1);
        rst_n = 1'b1;
        tick();
        chk("first_pos_x", int'(pos_x), 1);
        chk("first_enable", int'(enable), 1);

        // One free-running frame: exactly one frame-start, no acks.
        f0 = fs_seen; a0 = ack_seen;
        repeat (c_frame) tick();
        chk("frame_start_per_frame", fs_seen - f0, 1);
        chk("no_ack_idle_frame", ack_seen - a0, 0);

        // Single-cycle request mid-frame; swap only at the frame wrap.
        run_until(8, 4);
        req = 1'b1; tick(); req = 1'b0;
        run_until(c_x_last, c_y_last);
        chk("sel_before_wrap", int'(sel_buff), 0);
        tick();
        chk("sel_after_wrap", int'(sel_buff), 1);
        chk("draw_after_wrap", int'(draw_buff), 0);
        chk("ack_at_origin", int'(swap_ack), 1);
        tick();
        chk("ack_single_cycle", int'(swap_ack), 0);

        // Request held across three frame boundaries.
        run_until(5, 5);
        a0 = ack_seen;
        req = 1'b1;
        repeat (3 * c_frame) tick();
        req = 1'b0;
        chk("held_ack_count", ack_seen - a0, 3);
        chk("held_sel", int'(sel_buff), 0);
        // Held request re-armed after the last ack; that swap still lands.
        repeat (2 * c_frame) tick();
        chk("rearmed_sel", int'(sel_buff), 1);

        // Request only on the last-pixel cycle swaps on that same edge.
        run_until(c_x_last, c_y_last);
        req = 1'b1; tick(); req = 1'b0;
        chk("last_pixel_ack", int'(swap_ack), 1);
        chk("last_pixel_sel", int'(sel_buff), 0);

        // Pending swap discarded by mid-frame reset.
        run_until(0, 5);
        req = 1'b1; tick(); req = 1'b0;
        sel_flip_prep();
        run_until(10, 9);
        a0 = ack_seen;
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        chk("reset_mid_sel", int'(sel_buff), 0);
        chk("reset_mid_ack", int'(swap_ack), 0);
        chk("reset_mid_x", int'(pos_x), 0);
        repeat (c_frame + 20) tick();
        chk("no_swap_after_reset", ack_seen - a0, 0);
        chk("sel_after_reset_frame", int'(sel_buff), 0);

        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Make the post-reset sel check meaningful: ensure a swap is pending
    // while sel is currently 1 would not hide a missing reset of SEL_BUFF.
    task automatic sel_flip_prep();
        if (esel == 1'b0) begin
            run_until(c_x_last, c_y_last);
            req = 1'b1; tick(); req = 1'b0;
            run_until(0, 5);
            req = 1'b1; tick(); req = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
